// File: rtl/range_ctrl_pkg.sv
// Shared definitions for the range counter controller.
//   state_e   : controller state encoding (idle, run, hold, done)
//   RstLo/Hi  : bounds restored on reset
//   RstPasses : pass count restored on reset
package range_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHold = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam int unsigned RstLo     = 3;
   localparam int unsigned RstHi     = 45;
   localparam int unsigned RstPasses = 1;

endpackage

// File: rtl/range_counter_core.sv
// Bounded up/down counter datapath.
//   clk, rst           : clock, asynchronous active-low reset (count -> RstVal)
//   load, load_val     : synchronous load, wins over en
//   en                 : advance one step this cycle
//   down               : 1 = count downward (lo..hi wraps hi->lo reversed)
//   lo, hi             : inclusive bounds
//   count              : current value
//   at_bound           : count sits on the bound where the next step wraps
//   wrap               : en && at_bound, one pulse per wrap
module range_counter_core #(
   parameter int unsigned      WIDTH  = 8,
   parameter logic [WIDTH-1:0] RstVal = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             down,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] count,
   output logic             at_bound,
   output logic             wrap
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      at_bound = down ? (count_q == lo) : (count_q == hi);
      wrap     = en && at_bound;
      count_d  = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         if (at_bound) begin
            count_d = down ? hi : lo;
         end else begin
            count_d = down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= RstVal;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/range_count_ctrl.sv
// Range counter controller: configuration handshake, pass counting and
// run/hold/done sequencing around range_counter_core.
//   clk, rst            : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready : configuration handshake (ready only in idle)
//   cfg_lo, cfg_hi      : bounds, rejected (cfg_err) when lo > hi
//   cfg_passes          : passes per run, 0 = free-run
//   cfg_down            : only with RANGE_CTRL_DOWN_EN; count downward
//   start, pause, abort : run control; abort overrides everything
//   count, busy         : current value, high in run or hold
//   wrap, done, cfg_err : single-cycle event pulses
// Optional feature macro: RANGE_CTRL_DOWN_EN (adds cfg_down).
module range_count_ctrl
   import range_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned PASS_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH-1:0]  cfg_lo,
   input  logic [WIDTH-1:0]  cfg_hi,
   input  logic [PASS_W-1:0] cfg_passes,
`ifdef RANGE_CTRL_DOWN_EN
   input  logic              cfg_down,
`endif
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              wrap,
   output logic              done,
   output logic              cfg_err
);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
   logic [PASS_W-1:0] passes_q, passes_d, pass_cnt_q, pass_cnt_d;
   logic              cfg_err_q, cfg_err_d;
   logic              down_q;
   logic              handshake, cfg_accept;
   logic              ld, en, at_bound;
   logic [WIDTH-1:0]  ld_val;

   // abort blocks the handshake so it can override configuration too
   assign cfg_ready  = (state_q == StIdle) && !abort;
   assign handshake  = cfg_valid && cfg_ready;
   assign cfg_accept = handshake && (cfg_lo <= cfg_hi);

`ifdef RANGE_CTRL_DOWN_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         down_q <= 1'b0;
      end else if (cfg_accept) begin
         down_q <= cfg_down;
      end
   end
`else
   assign down_q = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      passes_d   = passes_q;
      pass_cnt_d = pass_cnt_q;
      cfg_err_d  = handshake && !cfg_accept;
      ld         = 1'b0;
      ld_val     = lo_q;
      en         = 1'b0;

      if (cfg_accept) begin
         lo_d     = cfg_lo;
         hi_d     = cfg_hi;
         passes_d = cfg_passes;
      end

      unique case (state_q)
         StIdle: begin
            // count tracks lo while idle, including a freshly accepted lo
            ld     = 1'b1;
            ld_val = lo_d;
            if (!abort && start && !handshake) begin
               state_d    = StRun;
               pass_cnt_d = passes_q;
               ld_val     = down_q ? hi_q : lo_q;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
               ld      = 1'b1;
            end else if (pause) begin
               state_d = StHold;
            end else begin
               en = 1'b1;
               if (at_bound && (passes_q != '0)) begin
                  if (pass_cnt_q <= PASS_W'(1)) begin
                     // final wrap: park on lo regardless of direction
                     state_d = StDone;
                     ld      = 1'b1;
                  end else begin
                     pass_cnt_d = pass_cnt_q - PASS_W'(1);
                  end
               end
            end
         end
         StHold: begin
            if (abort) begin
               state_d = StIdle;
               ld      = 1'b1;
            end else if (!pause) begin
               state_d = StRun;
            end
         end
         StDone: begin
            state_d = StIdle;
            ld      = 1'b1;
         end
         default: begin
            state_d = StIdle;
            ld      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         lo_q       <= WIDTH'(RstLo);
         hi_q       <= WIDTH'(RstHi);
         passes_q   <= PASS_W'(RstPasses);
         pass_cnt_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         passes_q   <= passes_d;
         pass_cnt_q <= pass_cnt_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   range_counter_core #(
      .WIDTH  (WIDTH),
      .RstVal (WIDTH'(RstLo))
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .en       (en),
      .down     (down_q),
      .lo       (lo_q),
      .hi       (hi_q),
      .count    (count),
      .at_bound (at_bound),
      .wrap     (wrap)
   );

   assign busy    = (state_q == StRun) || (state_q == StHold);
   assign done    = (state_q == StDone) && !abort;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_range_count_ctrl.sv
module tb_range_count_ctrl;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned PASS_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_valid, cfg_ready;
   logic [WIDTH-1:0]  cfg_lo, cfg_hi;
   logic [PASS_W-1:0] cfg_passes;
   logic              start, pause, abort;
   logic [WIDTH-1:0]  count;
   logic              busy, wrap, done, cfg_err;

   range_count_ctrl #(
      .WIDTH  (WIDTH),
      .PASS_W (PASS_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_lo     (cfg_lo),
      .cfg_hi     (cfg_hi),
      .cfg_passes (cfg_passes),
      .start      (start),
      .pause      (pause),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .wrap       (wrap),
      .done       (done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: configuration, position, passes remaining and phase flags
   int m_lo, m_hi, m_passes, m_cnt, m_left;
   bit m_active, m_hold, m_fin, m_err;

   int n_wrap, n_done, n_busy;
   int seq[$];

   task automatic model_reset();
      m_lo = 3; m_hi = 45; m_passes = 1; m_cnt = 3; m_left = 0;
      m_active = 0; m_hold = 0; m_fin = 0; m_err = 0;
   endtask

   task automatic clear_inputs();
      cfg_valid = 0; cfg_lo = '0; cfg_hi = '0; cfg_passes = '0;
      start = 0; pause = 0; abort = 0;
   endtask

   // Called at a falling edge with inputs applied; checks, then advances one clock.
   task automatic cycle();
      bit idle, e_ready, e_wrap, e_done, hs, ok;
      #1;
      idle    = !m_active && !m_fin;
      e_ready = idle && !abort;
      e_wrap  = m_active && !m_hold && !pause && !abort && (m_cnt == m_hi);
      e_done  = m_fin && !abort;
      check_eq("count",     int'(count),     m_cnt);
      check_eq("busy",      int'(busy),      int'(m_active));
      check_eq("wrap",      int'(wrap),      int'(e_wrap));
      check_eq("done",      int'(done),      int'(e_done));
      check_eq("cfg_err",   int'(cfg_err),   int'(m_err));
      check_eq("cfg_ready", int'(cfg_ready), int'(e_ready));
      if (wrap === 1'b1) n_wrap++;
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) begin
         n_busy++;
         seq.push_back(int'(count));
      end
      @(posedge clk);
      hs    = e_ready && cfg_valid;
      ok    = cfg_lo <= cfg_hi;
      m_err = hs && !ok;
      if (m_fin) begin
         m_fin = 0;
      end else if (idle) begin
         if (hs && ok) begin
            m_lo = int'(cfg_lo); m_hi = int'(cfg_hi); m_passes = int'(cfg_passes);
         end
         m_cnt = m_lo;
         if (!abort && start && !hs) begin
            m_active = 1; m_hold = 0; m_left = m_passes;
         end
      end else if (abort) begin
         m_active = 0; m_hold = 0; m_cnt = m_lo;
      end else if (m_hold) begin
         if (!pause) m_hold = 0;
      end else if (pause) begin
         m_hold = 1;
      end else if (m_cnt == m_hi) begin
         m_cnt = m_lo;
         if (m_passes != 0) begin
            m_left--;
            if (m_left == 0) begin
               m_active = 0; m_fin = 1;
            end
         end
      end else begin
         m_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic configure(input int lo, input int hi, input int passes);
      cfg_valid = 1; cfg_lo = WIDTH'(lo); cfg_hi = WIDTH'(hi); cfg_passes = PASS_W'(passes);
      cycle();
      cfg_valid = 0;
   endtask

   task automatic kick();
      n_wrap = 0; n_done = 0; n_busy = 0; seq.delete();
      start = 1;
      cycle();
      start = 0;
   endtask

   task automatic run_to_idle(input int budget);
      int g = 0;
      while ((busy === 1'b1 || done === 1'b1) && g < budget) begin
         cycle();
         g++;
      end
      check_eq("run_ends", int'(busy || done), 0);
   endtask

   task automatic run_to_count(input int target, input int budget);
      int g = 0;
      while (int'(count) != target && g < budget) begin
         cycle();
         g++;
      end
      check_eq("reach_count", int'(count), target);
   endtask

   initial begin
      int exp_seq[6] = '{10, 11, 12, 10, 11, 12};
      clear_inputs();
      model_reset();
      rst = 0;
      @(negedge clk);
      #1;
      check_eq("rst_count", int'(count), 3);
      check_eq("rst_busy", int'(busy), 0);
      rst = 1;
      @(negedge clk);

      // Defaults: 3..45, one pass
      kick();
      run_to_idle(100);
      check_eq("def_busy_cycles", n_busy, 43);
      check_eq("def_wraps", n_wrap, 1);
      check_eq("def_dones", n_done, 1);
      cycle();

      // 10..12 two passes
      configure(10, 12, 2);
      kick();
      run_to_idle(50);
      check_eq("p2_wraps", n_wrap, 2);
      check_eq("p2_dones", n_done, 1);
      check_eq("p2_len", seq.size(), 6);
      for (int i = 0; i < 6 && i < seq.size(); i++) check_eq("p2_seq", seq[i], exp_seq[i]);

      // Rejected configuration keeps old bounds
      configure(20, 5, 3);
      #1 check_eq("cfg_err_pulse", int'(cfg_err), 1);
      cycle();
      check_eq("cfg_err_clear", int'(cfg_err), 0);
      kick();
      check_eq("old_lo_start", int'(count), 10);
      run_to_idle(50);
      check_eq("old_bounds_len", seq.size(), 6);

      // Pause at 30
      configure(25, 40, 1);
      kick();
      run_to_count(30, 50);
      pause = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("pause_count", int'(count), 30);
         check_eq("pause_busy", int'(busy), 1);
      end
      pause = 0;
      run_to_count(31, 10);
      run_to_idle(100);

      // Abort in free-run
      configure(15, 60, 0);
      kick();
      run_to_count(17, 20);
      abort = 1;
      cycle();
      abort = 0;
      check_eq("abort_busy", int'(busy), 0);
      check_eq("abort_count", int'(count), 15);
      check_eq("abort_done", int'(done), 0);
      kick();
      check_eq("restart_count", int'(count), 15);
      check_eq("restart_busy", int'(busy), 1);
      abort = 1;
      cycle();
      abort = 0;

      // lo == hi: every cycle wraps
      configure(7, 7, 3);
      kick();
      run_to_idle(20);
      check_eq("eq_wraps", n_wrap, 3);
      check_eq("eq_dones", n_done, 1);

      // Reset mid-run
      configure(30, 50, 1);
      kick();
      run_to_count(40, 20);
      rst = 0;
      #1;
      check_eq("midrst_count", int'(count), 3);
      check_eq("midrst_busy", int'(busy), 0);
      check_eq("midrst_done", int'(done), 0);
      model_reset();
      @(negedge clk);
      rst = 1;
      cycle();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         int lo;
         lo         = int'($urandom_range(0, 250));
         cfg_valid  = ($urandom_range(0, 9) == 0);
         cfg_lo     = WIDTH'(lo);
         cfg_hi     = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom_range(0, 255))
                                                  : WIDTH'(lo + int'($urandom_range(0, 5)));
         cfg_passes = PASS_W'($urandom_range(0, 3));
         start      = ($urandom_range(0, 4) == 0);
         pause      = ($urandom_range(0, 6) == 0);
         abort      = ($urandom_range(0, 40) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
